// File: rtl/rv_mat_pkg.sv
// Shared definitions for the matrix load/store path: sequencer state,
// the write-select code that marks a matrix access, and beat geometry.
package rv_mat_pkg;

  localparam int MAT_W          = 128;
  localparam int DW             = 32;
  localparam int MAT_BEATS      = 4;
  localparam int MAT_ALIGN_BITS = 4;

  localparam logic [1:0] W_SEL_MAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mat_state_e;

  // Byte address of beat 'cnt' of an access starting at 'base'.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] cnt);
    return base + {28'd0, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/mem_mat_seq_if.sv
// Data-memory beat port owned by the matrix sequencer while it is busy.
interface mem_mat_seq_if #(parameter int DW = 32);

  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/mem_mat_seq.sv
// MEM-stage sequencer: splits a 128-bit matrix load/store into four 32-bit
// data-memory beats, stalls the pipeline while it runs, and presents the
// assembled load data to write-back with a one-cycle valid pulse.
module mem_mat_seq
  import rv_mat_pkg::*;
#(
  parameter int MAT_W = 128,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             me_mem_read,
  input  logic             me_mem_write,
  input  logic [1:0]       me_w_select,
  input  logic [31:0]      me_alu_o,
  input  logic [MAT_W-1:0] me_matrix_o,
  mem_mat_seq_if.master    dmem,
  output logic             stall_o,
  output logic             mat_busy_o,
  output logic [MAT_W-1:0] mat_rdata_o,
  output logic             mat_valid_o,
  output logic             mat_err_o
);

  mat_state_e                    state;
  logic [1:0]                    cnt;
  logic [31:0]                   base;
  logic                          dir_write;
  logic [MAT_BEATS-1:0][DW-1:0]  wr_words;
  logic [MAT_BEATS-1:0][DW-1:0]  rd_words;

  logic mop;
  logic illegal;
  logic start;
  logic busy;
  logic last_beat;

  // A new matrix op is only looked at in IDLE (never in DONE, where the
  // retiring instruction is still visible) and never while in reset.
  assign mop       = rst && (state == ST_IDLE) && (me_w_select == W_SEL_MAT)
                     && (me_mem_read || me_mem_write);
  assign illegal   = (me_mem_read && me_mem_write)
                     || (me_alu_o[MAT_ALIGN_BITS-1:0] != {MAT_ALIGN_BITS{1'b0}});
  assign start     = mop && !illegal;
  assign busy      = (state == ST_BUSY);
  assign last_beat = (cnt == 2'(MAT_BEATS - 1));

  // Sequencer state, beat counter, request latch and load-data assembly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      base      <= 32'd0;
      dir_write <= 1'b0;
      wr_words  <= '0;
      rd_words  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base      <= me_alu_o;
            dir_write <= me_mem_write;
            wr_words  <= me_matrix_o;
            cnt       <= 2'd0;
            state     <= ST_BUSY;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (dmem.ready) begin
            if (!dir_write) begin
              rd_words[cnt] <= dmem.rdata;
            end
            cnt <= cnt + 2'd1;
            if (last_beat) begin
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end else begin
            state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat port is driven only while busy so the external mux sees zeros otherwise.
  assign dmem.req   = busy;
  assign dmem.we    = busy && dir_write;
  assign dmem.addr  = busy ? beat_addr(base, cnt) : 32'd0;
  assign dmem.wdata = busy ? wr_words[cnt] : {DW{1'b0}};

  // Stall is raised in the detect cycle itself so EX/MEM holds the instruction.
  assign stall_o     = busy || start;
  assign mat_busy_o  = busy;
  assign mat_valid_o = (state == ST_DONE);
  assign mat_err_o   = mop && illegal;
  assign mat_rdata_o = rd_words;

endmodule

// File: tb/tb_mem_mat_seq.sv
// Directed bench for mem_mat_seq: loads, stores, wait states, rejected
// accesses, mid-access reset and back-to-back loads.
module tb_mem_mat_seq;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   w_select;
  logic [31:0]  alu;
  logic [127:0] matrix;
  logic         ready;
  logic         stall;
  logic         busy;
  logic [127:0] rdata;
  logic         valid;
  logic         err;

  logic [31:0]  mem [16];
  int           total_cnt;
  int           pass_cnt;

  mem_mat_seq_if bus ();

  assign bus.ready = ready;
  assign bus.rdata = mem[bus.addr[5:2]];

  mem_mat_seq dut (
    .clk         (clk),
    .rst         (rst),
    .me_mem_read (mem_read),
    .me_mem_write(mem_write),
    .me_w_select (w_select),
    .me_alu_o    (alu),
    .me_matrix_o (matrix),
    .dmem        (bus),
    .stall_o     (stall),
    .mat_busy_o  (busy),
    .mat_rdata_o (rdata),
    .mat_valid_o (valid),
    .mat_err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    w_select  = 2'b00;
    alu       = 32'd0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    mem[4] = 32'h55555555; mem[5] = 32'h66666666;
    mem[6] = 32'h77777777; mem[7] = 32'h88888888;
    rst = 1'b0; ready = 1'b1; matrix = 128'd0;
    clear_ops();
    step(); step();
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req", bus.req, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_rdata", rdata, 128'd0);
    rst = 1'b1;
    step();

    // Load at 0x100, ready high.
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h100;
    #1;
    check("t1_detect_stall", stall, 1'b1);
    check("t1_detect_req", bus.req, 1'b0);
    for (int b = 0; b < 4; b++) begin
      step(); #1;
      check("t1_req", bus.req, 1'b1);
      check("t1_addr", bus.addr, 32'h100 + 32'(4 * b));
      check("t1_we", bus.we, 1'b0);
      check("t1_stall", stall, 1'b1);
      check("t1_busy", busy, 1'b1);
    end
    step(); #1;
    check("t1_valid", valid, 1'b1);
    check("t1_done_stall", stall, 1'b0);
    check("t1_done_req", bus.req, 1'b0);
    check("t1_rdata", rdata, 128'h44444444_33333333_22222222_11111111);
    clear_ops();
    step(); #1;
    check("t1_valid_pulse", valid, 1'b0);

    // Store at 0x200.
    mem_write = 1'b1; w_select = 2'b11; alu = 32'h200;
    matrix = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    #1;
    check("t2_detect_stall", stall, 1'b1);
    step(); #1;
    check("t2_addr0", bus.addr, 32'h200);
    check("t2_wdata0", bus.wdata, 32'hAAAAAAAA);
    check("t2_we0", bus.we, 1'b1);
    step(); #1;
    check("t2_wdata1", bus.wdata, 32'hBBBBBBBB);
    step(); #1;
    check("t2_wdata2", bus.wdata, 32'hCCCCCCCC);
    step(); #1;
    check("t2_addr3", bus.addr, 32'h20C);
    check("t2_wdata3", bus.wdata, 32'hDDDDDDDD);
    check("t2_we3", bus.we, 1'b1);
    step(); #1;
    check("t2_valid", valid, 1'b1);
    check("t2_rdata_kept", rdata, 128'h44444444_33333333_22222222_11111111);
    clear_ops(); matrix = 128'd0;
    step();

    // Load at 0x110 with two wait cycles on beat 1.
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h110;
    #1;
    check("t3_detect_stall", stall, 1'b1);
    step(); #1;
    check("t3_addr0", bus.addr, 32'h110);
    step(); ready = 1'b0; #1;
    check("t3_wait1_addr", bus.addr, 32'h114);
    step(); #1;
    check("t3_wait2_addr", bus.addr, 32'h114);
    check("t3_wait2_stall", stall, 1'b1);
    step(); ready = 1'b1; #1;
    check("t3_accept_addr", bus.addr, 32'h114);
    step(); #1;
    check("t3_addr2", bus.addr, 32'h118);
    step(); #1;
    check("t3_addr3", bus.addr, 32'h11C);
    check("t3_no_early_valid", valid, 1'b0);
    step(); #1;
    check("t3_valid", valid, 1'b1);
    check("t3_rdata", rdata, 128'h88888888_77777777_66666666_55555555);
    clear_ops();
    step();

    // Misaligned load and read+write both set are rejected.
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h104;
    #1;
    check("t4_mis_err", err, 1'b1);
    check("t4_mis_stall", stall, 1'b0);
    check("t4_mis_req", bus.req, 1'b0);
    clear_ops();
    step(); #1;
    check("t4_mis_after_busy", busy, 1'b0);
    check("t4_mis_after_err", err, 1'b0);
    mem_read = 1'b1; mem_write = 1'b1; w_select = 2'b11; alu = 32'h100;
    #1;
    check("t4_rw_err", err, 1'b1);
    check("t4_rw_stall", stall, 1'b0);
    clear_ops();
    step(); #1;
    check("t4_rw_after_req", bus.req, 1'b0);

    // Reset during beat 2, then a clean load.
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h100;
    step(); step(); step(); #1;
    check("t5_beat2_addr", bus.addr, 32'h108);
    rst = 1'b0; clear_ops();
    #1;
    check("t5_rst_cycle_stall", stall, 1'b1);
    step(); #1;
    check("t5_after_stall", stall, 1'b0);
    check("t5_after_busy", busy, 1'b0);
    check("t5_after_req", bus.req, 1'b0);
    check("t5_after_addr", bus.addr, 32'd0);
    check("t5_after_valid", valid, 1'b0);
    check("t5_after_rdata", rdata, 128'd0);
    rst = 1'b1;
    step(); #1;
    check("t5_no_valid", valid, 1'b0);
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h100;
    for (int c = 0; c < 5; c++) step();
    #1;
    check("t5_reload_valid", valid, 1'b1);
    check("t5_reload_rdata", rdata, 128'h44444444_33333333_22222222_11111111);
    clear_ops();
    step();

    // Back-to-back loads at 0x100 then 0x110.
    mem_read = 1'b1; w_select = 2'b11; alu = 32'h100;
    for (int c = 0; c < 5; c++) step();
    #1;
    check("t6_first_valid", valid, 1'b1);
    check("t6_no_retrigger_stall", stall, 1'b0);
    check("t6_no_dup_req", bus.req, 1'b0);
    check("t6_first_rdata", rdata, 128'h44444444_33333333_22222222_11111111);
    step(); alu = 32'h110; #1;
    check("t6_second_detect", stall, 1'b1);
    check("t6_second_not_busy", busy, 1'b0);
    step(); #1;
    check("t6_second_addr0", bus.addr, 32'h110);
    step(); step(); step(); step(); #1;
    check("t6_second_valid", valid, 1'b1);
    check("t6_second_rdata", rdata, 128'h88888888_77777777_66666666_55555555);
    clear_ops();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_mat_seq.md
# mem_mat_seq

Memory-stage sequencer for 128-bit matrix loads/stores in the RV pipeline. Watches the MEM-stage control/data outputs of the EX/MEM pipeline register and splits each matrix access into four 32-bit data-memory beats. While it runs, it stalls the pipeline so the EX/MEM register holds the instruction. It then presents the assembled 128-bit load result to write-back. Scalar accesses never touch this block; the external dmem mux selects this block's port while `mat_busy_o` is high.

## Interface
- `MAT_W`, 128: matrix data width.
- `DW`, 32: data-memory beat width; `MAT_W/DW` = 4 beats.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, synchronous, active-low.
- `me_mem_read  in  1`: MEM-stage load.
- `me_mem_write  in  1`: MEM-stage store.
- `me_w_select  in  2`: write-select; `2'b11` marks a matrix access.
- `me_alu_o  in  32`: base byte address.
- `me_matrix_o  in  128`: matrix store data.
- `dmem_req  out  1`: beat request.
- `dmem_we  out  1`: beat is a write.
- `dmem_addr  out  32`: beat byte address.
- `dmem_wdata  out  32`: beat write data.
- `dmem_ready  in  1`: beat accepted; read data valid this cycle.
- `dmem_rdata  in  32`: beat read data.
- `stall_o  out  1`: hold PC, IF/ID, ID/EX, EX/MEM.
- `mat_busy_o  out  1`: dmem port owned by this block.
- `mat_rdata_o  out  128`: assembled load data.
- `mat_valid_o  out  1`: one-cycle pulse; load/store complete.
- `mat_err_o  out  1`: one-cycle pulse; access rejected.

## Operation
- Matrix op (`mop`) = `me_w_select==2'b11 && (me_mem_read || me_mem_write)`.
- Illegal: read and write both set, or `me_alu_o[3:0]!=0` (matrix accesses are 16-byte aligned).
  - Response: `mat_err_o`=1 for that cycle, no beats, no stall, stay IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a legal `mop`, latch base, direction and `me_matrix_o`; clear beat counter `cnt` (2 bits).
  - `stall_o`=1 combinationally in that cycle; next state BUSY.
- BUSY:
  - Drives `dmem_req`=1, `dmem_addr`=base+4*cnt, `dmem_we`=direction, `dmem_wdata`=latched data[32*cnt +: 32].
  - Requests hold stable until `dmem_ready`.
  - On `dmem_ready`, a load stores `dmem_rdata` into `mat_rdata_o[32*cnt +: 32]`; `cnt` increments.
  - Ready with `cnt==3` -> DONE.
  - `stall_o`=1 throughout.
- DONE:
  - `stall_o`=0, so EX/MEM advances at this edge.
  - `mat_valid_o`=1, `mat_rdata_o` complete; next state IDLE.
  - A new `mop` is not sampled in DONE, which prevents re-triggering on the retiring instruction.
- `mat_busy_o`=1 in BUSY.
- `mat_rdata_o` holds its value until the next load's first beat overwrites word 0.
- Stores leave `mat_rdata_o` unchanged.
- Address arithmetic is 32-bit, modulo 2^32. With alignment enforced, no wrap occurs within one access.

## Timing
- Reset values: state IDLE, `cnt`=0, `mat_rdata_o`=0, latched data/address 0.
- All outputs are 0 in reset and in IDLE with no `mop`.
- `rst` low mid-access:
  - Next edge forces IDLE; the beat in flight is abandoned.
  - No `mat_valid_o`; `stall_o` drops the cycle after the reset edge.
- Latency with `dmem_ready` tied high:
  - Detect cycle T; beats T+1..T+4; DONE at T+5.
  - `stall_o` high T..T+4 (5 cycles); `mat_valid_o` at T+5.
- Each wait cycle (`dmem_ready`=0) in BUSY adds exactly one cycle.
- `dmem_ready` outside BUSY is ignored.
- A matrix op immediately following another is detected in the cycle after DONE.

## Structure
- Package `rv_mat_pkg`: state enum, `W_SEL_MAT`=2'b11, `MAT_BEATS`=4, `MAT_ALIGN_BITS`=4.
- Shared with the EX-stage matrix unit and the write-back mux.
- Single flat module; no sub-module. The beat counter and data latch are too small to split.

## Test plan
- Load at 0x100, memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444, ready high:
  - addrs 0x100/0x104/0x108/0x10C;
  - `mat_rdata_o`=0x44444444_33333333_22222222_11111111;
  - `stall_o` 5 cycles, valid at T+5.
- Store 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA at 0x200:
  - four writes, wdata AAAAAAAA first at 0x200, DDDDDDDD last at 0x20C, `dmem_we`=1;
  - `mat_rdata_o` unchanged.
- Load with `dmem_ready` low 2 cycles on beat 1:
  - `dmem_addr` holds 0x104;
  - valid at T+7; data correct.
- Load at 0x104:
  - `mat_err_o` pulse; no `dmem_req`; `stall_o`=0.
  - Same for read+write both set.
- `rst` low during beat 2:
  - next cycle all outputs 0, IDLE, no `mat_valid_o`;
  - a subsequent load at 0x100 completes normally.
- Back-to-back loads at 0x100 and 0x110:
  - second detected at T+6; no duplicate access for the first.
